// File: rtl/ps2_kbd_rx_if.sv
// Read-side bus between the PS/2 receiver and the bus decoder that serves CPU reads.
// master = receiver (produces scan codes), slave = decoder (pops them).
interface ps2_kbd_rx_if;
    logic       rd_en;
    logic       ps2_ready;
    logic [7:0] ps2_data;
    logic       overflow;
    logic       frame_err;

    modport master (
        input  rd_en,
        output ps2_ready,
        output ps2_data,
        output overflow,
        output frame_err
    );

    modport slave (
        output rd_en,
        input  ps2_ready,
        input  ps2_data,
        input  overflow,
        input  frame_err
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and filters the device lines, deframes
// 11-bit frames and queues good scan codes in a show-ahead FIFO.
module ps2_kbd_rx #(
    parameter int FIFO_AW     = 3,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ps2_clk,
    input  logic            ps2_dat,
    ps2_kbd_rx_if.master    bus
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_CHECK
    } state_t;

    logic [1:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;
    logic             filt_q;
    logic             filt_prev_q;
    logic [FLT_W-1:0] flt_cnt_q;

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       frame_q, frame_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;

    logic fall, dat_s, good, full, empty, pop, push, ovf_set;

    // Synchronisers and the clock-line glitch filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            flt_cnt_q   <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            dat_sync_q  <= {dat_sync_q[0], ps2_dat};
            filt_prev_q <= filt_q;
            if (clk_sync_q[1] == filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                filt_q    <= clk_sync_q[1];
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    assign fall  = filt_prev_q & ~filt_q;
    assign dat_s = dat_sync_q[1];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop   = bus.rd_en && !empty;

    // Odd parity: data bits plus parity bit must contain an odd number of ones
    assign good    = (^frame_q[7:0] ^ frame_q[8]) & frame_q[9];
    assign push    = (state_q == S_CHECK) && good && (!full || pop);
    assign ovf_set = (state_q == S_CHECK) && good && full && !pop;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        to_d        = to_q;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                to_d      = '0;
                bit_cnt_d = '0;
                if (fall && !dat_s) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (fall) begin
                    frame_d = {dat_s, frame_q[9:1]};
                    to_d    = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d   = S_CHECK;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                    to_d        = '0;
                    bit_cnt_d   = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_d     = S_IDLE;
                frame_err_d = !good;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (pop) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            to_q        <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            to_q        <= to_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage carries no reset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= frame_q[7:0];
        end
    end

    assign bus.ps2_ready = !empty;
    assign bus.ps2_data  = empty ? 8'h00 : mem[rd_ptr_q[FIFO_AW-1:0]];
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames with a 16-cycle bit period
// and compares outputs against hand-computed values.
module tb_ps2_kbd_rx;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic ps2_clk;
    logic ps2_dat;

    ps2_kbd_rx_if bus_if ();

    ps2_kbd_rx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int fall_cyc     = 0;
    int rise_cyc     = 0;
    int err_cnt      = 0;
    logic rdy_prev   = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus_if.frame_err === 1'b1) err_cnt++;
        if (bus_if.ps2_ready === 1'b1 && rdy_prev !== 1'b1) rise_cyc = cyc;
        rdy_prev = bus_if.ps2_ready;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends the first nbits bits of a frame; optionally raises rd_en for one
    // cycle at negedge pop_at after the last falling edge, returning the head seen.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input int nbits,
                              input int pop_at, output logic [7:0] popped);
        logic [10:0] fr;
        fr = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        popped = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            repeat (HALF) @(negedge clk);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            for (int j = 1; j <= HALF; j++) begin
                @(negedge clk);
                if (i == nbits - 1 && pop_at == j) begin
                    popped = bus_if.ps2_data;
                    bus_if.rd_en = 1'b1;
                end else begin
                    bus_if.rd_en = 1'b0;
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk);
        $display("[TB] frame %02h sent (%0d bits, bad_par=%0b)", d, nbits, bad_par);
    endtask

    task automatic send(input logic [7:0] d);
        logic [7:0] unused;
        send_frame(d, 1'b0, 11, 0, unused);
    endtask

    task automatic pop_one(output logic [7:0] d);
        d = bus_if.ps2_data;
        bus_if.rd_en = 1'b1;
        @(negedge clk);
        bus_if.rd_en = 1'b0;
        $display("[TB] pop -> %02h", d);
    endtask

    initial begin
        logic [7:0] d;
        int e0;

        rst_n        = 1'b0;
        ps2_clk      = 1'b1;
        ps2_dat      = 1'b1;
        bus_if.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus_if.ps2_ready), 32'h0);
        check("rst_data",  32'(bus_if.ps2_data),  32'h0);
        check("rst_ovf",   32'(bus_if.overflow),  32'h0);
        check("rst_err",   32'(bus_if.frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single good frame and its latency from the stop-bit clock drop
        send(8'h1C);
        check("t1_latency", 32'(rise_cyc - fall_cyc), 32'd8);
        check("t1_ready",   32'(bus_if.ps2_ready),   32'h1);
        check("t1_data",    32'(bus_if.ps2_data),    32'h1C);
        pop_one(d);
        check("t1_ready_after_pop", 32'(bus_if.ps2_ready), 32'h0);
        check("t1_data_empty",      32'(bus_if.ps2_data),  32'h0);

        // Parity error
        e0 = err_cnt;
        send_frame(8'h5A, 1'b1, 11, 0, d);
        check("t2_err_pulses", 32'(err_cnt - e0),     32'd1);
        check("t2_ready",      32'(bus_if.ps2_ready), 32'h0);

        // Overfill by one
        for (int k = 1; k <= 9; k++) send(8'(k));
        check("t3_ready", 32'(bus_if.ps2_ready), 32'h1);
        check("t3_ovf",   32'(bus_if.overflow),  32'h1);
        pop_one(d);
        check("t3_pop1", 32'(d), 32'h01);
        check("t3_ovf_cleared", 32'(bus_if.overflow), 32'h0);
        for (int k = 2; k <= 8; k++) begin
            pop_one(d);
            check($sformatf("t3_pop%0d", k), 32'(d), 32'(k));
        end
        check("t3_empty", 32'(bus_if.ps2_ready), 32'h0);
        pop_one(d);
        check("t3_pop_empty_ignored", 32'(bus_if.ps2_ready), 32'h0);

        // Truncated frame and the timeout boundary
        e0 = err_cnt;
        send_frame(8'hAA, 1'b0, 6, 0, d);
        repeat (49000) @(negedge clk);
        check("t4_no_early_timeout", 32'(err_cnt - e0), 32'd0);
        repeat (1100) @(negedge clk);
        check("t4_timeout_err", 32'(err_cnt - e0),     32'd1);
        check("t4_ready",       32'(bus_if.ps2_ready), 32'h0);
        send(8'hF0);
        pop_one(d);
        check("t4_after_timeout", 32'(d), 32'hF0);

        // Short glitch on the clock line with data low
        e0 = err_cnt;
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_dat = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_ready", 32'(bus_if.ps2_ready), 32'h0);
        send(8'h33);
        check("t5_no_err", 32'(err_cnt - e0), 32'd0);
        pop_one(d);
        check("t5_data", 32'(d), 32'h33);

        // Full FIFO, push coinciding with pop in the CHECK cycle
        for (int k = 0; k < 8; k++) send(8'h10 + 8'(k));
        check("t6_ovf_before", 32'(bus_if.overflow), 32'h0);
        send_frame(8'h18, 1'b0, 11, 7, d);
        check("t6_popped_head", 32'(d), 32'h10);
        check("t6_ovf_after",   32'(bus_if.overflow), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            pop_one(d);
            check($sformatf("t6_pop%0d", k), 32'(d), 32'h10 + 32'(k));
        end
        check("t6_empty", 32'(bus_if.ps2_ready), 32'h0);

        // Reset in the middle of a frame
        send(8'h22);
        for (int k = 0; k < 8; k++) send(8'h60);
        check("t7_ovf_set", 32'(bus_if.overflow), 32'h1);
        e0 = err_cnt;
        send_frame(8'h77, 1'b0, 4, 0, d);
        rst_n = 1'b0;
        #1;
        check("t7_rst_ready", 32'(bus_if.ps2_ready), 32'h0);
        check("t7_rst_data",  32'(bus_if.ps2_data),  32'h0);
        check("t7_rst_ovf",   32'(bus_if.overflow),  32'h0);
        check("t7_rst_err",   32'(bus_if.frame_err), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h44);
        check("t7_no_err", 32'(err_cnt - e0), 32'd0);
        pop_one(d);
        check("t7_data", 32'(d), 32'h44);
        check("t7_empty", 32'(bus_if.ps2_ready), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
